object_bbox_zones: RTL



---
 rtl/object_bbox_zones_pkg.sv | 22 ++
 rtl/bbox_zone_acc.sv | 51 +++++
 rtl/object_bbox_zones.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/object_bbox_zones_pkg.sv
// Shared types for object_bbox_zones: result-FSM encoding and the per-zone bbox record.
// The record is sized for the widest supported coordinate/count; users truncate to CW/CNT_W.
package object_bbox_zones_pkg;

    localparam int unsigned BBOX_CW_MAX  = 16;
    localparam int unsigned BBOX_CNT_MAX = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLatch = 2'd1,
        StSend  = 2'd2
    } bbox_state_e;

    typedef struct packed {
        logic [BBOX_CW_MAX-1:0]  up;
        logic [BBOX_CW_MAX-1:0]  down;
        logic [BBOX_CW_MAX-1:0]  left;
        logic [BBOX_CW_MAX-1:0]  right;
        logic [BBOX_CNT_MAX-1:0] count;
    } bbox_t;

endpackage

// File: rtl/bbox_zone_acc.sv
// Single-zone bounding-box accumulator: tracks min/max of x and y plus a saturating hit count.
module bbox_zone_acc
    import object_bbox_zones_pkg::*;
#(
    parameter int unsigned CW    = 11,
    parameter int unsigned CNT_W = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          hit,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    output bbox_t         box
);

    logic [CW-1:0]    min_x_q, max_x_q, min_y_q, max_y_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_x_q <= '1;
            max_x_q <= '0;
            min_y_q <= '1;
            max_y_q <= '0;
            count_q <= '0;
        end else if (clr) begin
            min_x_q <= '1;
            max_x_q <= '0;
            min_y_q <= '1;
            max_y_q <= '0;
            count_q <= '0;
        end else if (hit) begin
            if (x < min_x_q) min_x_q <= x;
            if (x > max_x_q) max_x_q <= x;
            if (y < min_y_q) min_y_q <= y;
            if (y > max_y_q) max_y_q <= y;
            if (count_q != '1) count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        box       = '0;
        box.up    = BBOX_CW_MAX'(min_y_q);
        box.down  = BBOX_CW_MAX'(max_y_q);
        box.left  = BBOX_CW_MAX'(min_x_q);
        box.right = BBOX_CW_MAX'(max_x_q);
        box.count = BBOX_CNT_MAX'(count_q);
    end

endmodule

// File: rtl/object_bbox_zones.sv
// Per-zone object bounding boxes over a binarised+edge frame, streamed out as valid/ready beats.
// Optional temporal smoothing of reported boxes: define BBOX_SMOOTH_EN.
module object_bbox_zones
    import object_bbox_zones_pkg::*;
#(
    parameter int unsigned IMG_HDISP  = 11'd1024,
    parameter int unsigned IMG_VDISP  = 11'd768,
    parameter int unsigned CW         = 11,
    parameter int unsigned NUM_ZONES  = 2,
    parameter int unsigned MIN_PIXELS = 16,
    parameter int unsigned CNT_W      = 20,
    localparam int unsigned ZW        = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic             per_img_bit,
    input  logic             per_img_sobel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ZW-1:0]    res_zone,
    output logic [CW-1:0]    res_up,
    output logic [CW-1:0]    res_down,
    output logic [CW-1:0]    res_left,
    output logic [CW-1:0]    res_right,
    output logic [CNT_W-1:0] res_count,
    output logic             res_hit,
    output logic             frame_done,
    output logic             overrun
);

    localparam int unsigned ZONE_W = IMG_HDISP / NUM_ZONES;

    logic [CW-1:0] x_q, y_q, zx_q;
    logic [ZW-1:0] zone_q;
    logic          last_x, last_y, frame_end, pix_hit;

    assign last_x    = (x_q == CW'(IMG_HDISP - 1));
    assign last_y    = (y_q == CW'(IMG_VDISP - 1));
    assign frame_end = per_frame_clken && !per_frame_vsync && last_x && last_y;
    assign pix_hit   = per_frame_clken && per_img_bit && per_img_sobel && !per_frame_vsync;

    // Zone index tracks x through a sub-counter so no divider is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0; y_q <= '0; zx_q <= '0; zone_q <= '0;
        end else if (per_frame_vsync) begin
            x_q <= '0; y_q <= '0; zx_q <= '0; zone_q <= '0;
        end else if (per_frame_clken) begin
            if (last_x) begin
                x_q    <= '0;
                zx_q   <= '0;
                zone_q <= '0;
                y_q    <= last_y ? '0 : y_q + CW'(1);
            end else begin
                x_q <= x_q + CW'(1);
                if (zx_q == CW'(ZONE_W - 1)) begin
                    zx_q   <= '0;
                    zone_q <= zone_q + ZW'(1);
                end else begin
                    zx_q <= zx_q + CW'(1);
                end
            end
        end
    end

    bbox_t acc_box [NUM_ZONES];

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        bbox_zone_acc #(
            .CW    (CW),
            .CNT_W (CNT_W)
        ) u_acc (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (per_frame_vsync),
            .hit   (pix_hit && (zone_q == ZW'(z))),
            .x     (x_q),
            .y     (y_q),
            .box   (acc_box[z])
        );
    end

    bbox_state_e state_q, state_d;
    logic [ZW-1:0] send_idx_q, send_idx_d;
    bbox_t         snap_q [NUM_ZONES];
    logic          frame_done_q, overrun_q, xfer, last_beat;

    assign res_valid = (state_q == StSend);
    assign xfer      = res_valid && res_ready;
    assign last_beat = (send_idx_q == ZW'(NUM_ZONES - 1));

    always_comb begin
        state_d    = state_q;
        send_idx_d = send_idx_q;
        unique case (state_q)
            StIdle:  if (frame_end) state_d = StLatch;
            StLatch: begin
                state_d    = StSend;
                send_idx_d = '0;
            end
            StSend: begin
                if (xfer) begin
                    if (last_beat) state_d = StIdle;
                    else           send_idx_d = send_idx_q + ZW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Snapshot is taken from the accumulator registers, so a vsync on the LATCH edge
    // still captures the finished frame while the clear lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            send_idx_q   <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int z = 0; z < NUM_ZONES; z++) snap_q[z] <= '0;
        end else begin
            state_q      <= state_d;
            send_idx_q   <= send_idx_d;
            frame_done_q <= xfer && last_beat;
            overrun_q    <= frame_end && (state_q != StIdle);
            if (state_q == StLatch) snap_q <= acc_box;
        end
    end

    bbox_t         sel;
    logic          sel_hit;
    logic [CW-1:0] raw_up, raw_down, raw_left, raw_right;
    logic [CW-1:0] box_up, box_down, box_left, box_right;

    assign sel       = snap_q[send_idx_q];
    assign sel_hit   = (CNT_W'(sel.count) >= CNT_W'(MIN_PIXELS));
    assign raw_up    = CW'(sel.up);
    assign raw_down  = CW'(sel.down);
    assign raw_left  = CW'(sel.left);
    assign raw_right = CW'(sel.right);

`ifdef BBOX_SMOOTH_EN
    logic [NUM_ZONES-1:0] hist_vld_q;
    logic [CW-1:0]        hist_up_q [NUM_ZONES];
    logic [CW-1:0]        hist_down_q [NUM_ZONES];
    logic [CW-1:0]        hist_left_q [NUM_ZONES];
    logic [CW-1:0]        hist_right_q [NUM_ZONES];

    function automatic logic [CW-1:0] avg_edge(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b} + (CW+1)'(1);
        return s[CW:1];
    endfunction

    always_comb begin
        box_up = raw_up; box_down = raw_down; box_left = raw_left; box_right = raw_right;
        if (hist_vld_q[send_idx_q]) begin
            box_up    = avg_edge(hist_up_q[send_idx_q], raw_up);
            box_down  = avg_edge(hist_down_q[send_idx_q], raw_down);
            box_left  = avg_edge(hist_left_q[send_idx_q], raw_left);
            box_right = avg_edge(hist_right_q[send_idx_q], raw_right);
        end
    end

    // History holds the previous frame's raw box; a missing zone invalidates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_vld_q <= '0;
            for (int z = 0; z < NUM_ZONES; z++) begin
                hist_up_q[z] <= '0; hist_down_q[z] <= '0;
                hist_left_q[z] <= '0; hist_right_q[z] <= '0;
            end
        end else if (xfer) begin
            hist_vld_q[send_idx_q] <= sel_hit;
            if (sel_hit) begin
                hist_up_q[send_idx_q]    <= raw_up;
                hist_down_q[send_idx_q]  <= raw_down;
                hist_left_q[send_idx_q]  <= raw_left;
                hist_right_q[send_idx_q] <= raw_right;
            end
        end
    end
`else
    assign box_up    = raw_up;
    assign box_down  = raw_down;
    assign box_left  = raw_left;
    assign box_right = raw_right;
`endif

    always_comb begin
        res_zone  = '0;
        res_up    = '0;
        res_down  = '0;
        res_left  = '0;
        res_right = '0;
        res_count = '0;
        res_hit   = 1'b0;
        if (res_valid) begin
            res_zone  = send_idx_q;
            res_count = CNT_W'(sel.count);
            res_hit   = sel_hit;
            if (sel_hit) begin
                res_up    = box_up;
                res_down  = box_down;
                res_left  = box_left;
                res_right = box_right;
            end
        end
    end

    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

    logic unused_sel;
    assign unused_sel = ^{sel, per_frame_href};

endmodule
